kernel_launch_arbiter: RTL and testbench
========================================

Name: kernel_launch_arbiter

Overview:
Shares one OpenCL kernel datapath between NUM_REQ launch requesters. Each requester is a host queue or a device-side enqueue engine. The block arbitrates round-robin and sequences the kernel's on/complete/clean/cleaned handshake for the granted request. It measures the launch duration, enforces an optional watchdog, and returns one completion record per launch. It sits between the requesters and the kernel control pins (rstn/select/on/complete/clean/cleaned).

Parameters:
NUM_REQ, 4, number of requesters (2..16)
SEL_W, 8, kernel select width
CNT_W, 48, cycle counter width
TIMEOUT_CYCLES, 0, watchdog limit in cycles; 0 = disabled
RST_CYCLES, 4, cycles k_rstn is held low during recovery (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester launch request; held until granted
req_select  in  NUM_REQ*SEL_W  per-requester kernel id; slice i at [i*SEL_W +: SEL_W]
req_grant  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
abort  in  1  force termination of the in-flight launch
busy  out  1  high in every state except IDLE
k_rstn  out  1  kernel reset, active-low
k_select  out  SEL_W  captured kernel id
k_on  out  1  1-cycle start pulse
k_complete  in  1  kernel finished
k_clean  out  1  1-cycle clean pulse
k_cleaned  in  1  clean finished
done_valid  out  1  1-cycle completion pulse
done_id  out  $clog2(NUM_REQ)  requester index of the completed launch
done_status  out  2  00 ok, 01 timeout, 10 abort
done_cycles  out  CNT_W  launch duration

Behaviour:
- Reset values: req_grant 0, k_rstn 0, k_on 0, k_clean 0, k_select 0, done_* 0, busy 0, state IDLE, rr pointer 0, counter 0. k_rstn goes 1 in the first cycle after reset deasserts.
- All outputs are registered.
- States: IDLE, LAUNCH, RUN, CLEAN, RECOVER, DONE.
- IDLE:
  - If abort=0 and any req_valid is high, select the first valid index at or after ptr (mod NUM_REQ).
  - Next cycle: req_grant[i]=1, k_on=1, k_select=req_select[i], counter=1, state LAUNCH, ptr=i+1 mod NUM_REQ.
  - No valid request, or abort=1: stay in IDLE with no grant.
- LAUNCH: lasts exactly 1 cycle; go to RUN. k_complete is ignored in this cycle.
- RUN:
  - Counter increments every cycle.
  - k_complete=1: next cycle k_clean=1, state CLEAN.
- CLEAN:
  - k_clean is high only in the first CLEAN cycle.
  - Counter increments every cycle.
  - k_cleaned is sampled in every CLEAN cycle, including the first. k_cleaned=1 → DONE, status 00.
- Watchdog:
  - Applies only when TIMEOUT_CYCLES≠0, in RUN or CLEAN.
  - Counter == TIMEOUT_CYCLES with no completing event that cycle → RECOVER, status 01.
  - If the event and the limit coincide, the event wins.
- abort=1 in LAUNCH/RUN/CLEAN → RECOVER, status 10. Abort takes priority over k_complete, k_cleaned and the watchdog in the same cycle. abort is ignored in RECOVER and DONE.
- RECOVER:
  - k_rstn=0, k_on=0, k_clean=0 for exactly RST_CYCLES cycles.
  - The counter is frozen.
  - Then DONE; k_rstn returns to 1 on entry to DONE.
- DONE:
  - Lasts 1 cycle: done_valid=1, with done_id, done_status and done_cycles=counter.
  - Then IDLE. Arbitration resumes in that IDLE cycle, so the next grant is possible 2 cycles after done_valid.
- Counter saturates at 2^CNT_W−1 and never wraps.
- req_valid is ignored outside IDLE. A requester deasserting valid before grant is legal; it loses its turn without penalty.
- done_* hold their last values between pulses; only done_valid pulses.

Test Plan:
1. Reset, then req_valid=0001, req_select[0]=0x05. Kernel asserts k_complete 10 cycles after k_on and k_cleaned 2 cycles after k_clean. Required: grant=0001 and k_on coincide, k_select=0x05; done_valid with id 0, status 00, done_cycles=14.
2. req_valid=1111 held, every kernel completes normally. Required: grant order 0,1,2,3,0; exactly one done per grant; no overlap of k_on between launches.
3. TIMEOUT_CYCLES=20, kernel never completes. Required:
   - RECOVER entered after the counter reaches 20.
   - k_rstn low for exactly 4 cycles.
   - done status 01, done_cycles=20.
   - The next request is granted normally afterwards.
4. abort pulsed in the same cycle as k_complete during RUN. Required: no k_clean; RECOVER with k_rstn low for 4 cycles; done status 10.
5. Reset asserted mid-RUN. Required: the next cycle shows k_rstn=0, k_on=0, done_valid=0, busy=0. After release, a request from index 2 is granted ahead of index 1 only if ptr permits; ptr=0 after reset, so index 1 wins.
6. abort held high in IDLE with req_valid=0010. Required: no grant while abort=1; grant=0010 the cycle after abort falls.

Source files
------------

// File: rtl/kernel_launch_arbiter.sv
// ---------------------------------------------------------------------------
// kernel_launch_arbiter
//
// Shares one OpenCL kernel datapath between NUM_REQ launch requesters.
// Requests are accepted round-robin. For the granted request the block
// drives the kernel handshake (on -> complete -> clean -> cleaned) and
// measures the launch duration in cycles. An optional watchdog and an
// external abort both end the launch through a kernel reset phase
// (RECOVER). Every launch returns exactly one completion record.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   req_valid[i]         requester i wants a launch (held until granted)
//   req_select           per-requester kernel id, slice i at [i*SEL_W +: SEL_W]
//   req_grant            one-hot 1-cycle pulse, request accepted
//   abort                force termination of the in-flight launch
//   busy                 high whenever the controller is not idle
//   k_rstn               kernel reset (active-low)
//   k_select             kernel id captured at grant
//   k_on                 1-cycle kernel start pulse
//   k_complete           kernel reports it has finished
//   k_clean              1-cycle clean pulse
//   k_cleaned            kernel reports clean is finished
//   done_valid           1-cycle completion pulse
//   done_id              requester index of the completed launch
//   done_status          00 ok, 01 watchdog timeout, 10 abort
//   done_cycles          launch duration (k_on cycle counts as 1)
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module kernel_launch_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int SEL_W          = 8,
   parameter int CNT_W          = 48,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int RST_CYCLES     = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*SEL_W-1:0]     req_select,
   output logic [NUM_REQ-1:0]           req_grant,
   input  logic                         abort,
   output logic                         busy,
   output logic                         k_rstn,
   output logic [SEL_W-1:0]             k_select,
   output logic                         k_on,
   input  logic                         k_complete,
   output logic                         k_clean,
   input  logic                         k_cleaned,
   output logic                         done_valid,
   output logic [$clog2(NUM_REQ)-1:0]   done_id,
   output logic [1:0]                   done_status,
   output logic [CNT_W-1:0]             done_cycles
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [RST_W-1:0]   RST_LOAD    = RST_W'(RST_CYCLES - 1);
   localparam logic [ID_W-1:0]    LAST_ID     = ID_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] GRANT_ONE   = NUM_REQ'(1);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ABORT   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_RUN     = 3'd2,
      S_CLEAN   = 3'd3,
      S_RECOVER = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
   logic [ID_W-1:0]      cur_id_q, cur_id_d;
   logic [1:0]           cur_status_q, cur_status_d;

   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 busy_q, busy_d;
   logic                 k_rstn_q, k_rstn_d;
   logic [SEL_W-1:0]     k_select_q, k_select_d;
   logic                 k_on_q, k_on_d;
   logic                 k_clean_q, k_clean_d;
   logic                 done_valid_q, done_valid_d;
   logic [ID_W-1:0]      done_id_q, done_id_d;
   logic [1:0]           done_status_q, done_status_d;
   logic [CNT_W-1:0]     done_cycles_q, done_cycles_d;

   logic                 pick_found_s;
   logic [ID_W-1:0]      pick_idx_s;
   logic [ID_W-1:0]      pick_next_s;
   logic [CNT_W-1:0]     cnt_inc_s;
   logic                 wd_hit_s;

   // Round-robin pick: first valid requester at or after ptr_q, wrapping.
   // The loop runs from the farthest offset down so the nearest one wins.
   always_comb begin
      int          cand;
      logic [ID_W-1:0] cand_idx;
      pick_found_s = |req_valid;
      pick_idx_s   = '0;
      cand         = 0;
      cand_idx     = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = int'(ptr_q) + off;
         cand = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
         cand_idx   = ID_W'(cand);
         pick_idx_s = req_valid[cand_idx] ? cand_idx : pick_idx_s;
      end
      pick_next_s = (pick_idx_s == LAST_ID) ? '0 : (pick_idx_s + ID_W'(1));
   end

   // Saturating counter increment and watchdog compare.
   // The compare is an equality: once the limit is passed on a completing
   // event the watchdog cannot fire again for this launch.
   always_comb begin
      cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
      wd_hit_s  = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LIM);
   end

   // Launch sequencer: next state and next values of all registered outputs.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      rst_cnt_d     = rst_cnt_q;
      cur_id_d      = cur_id_q;
      cur_status_d  = cur_status_q;
      grant_d       = '0;
      k_select_d    = k_select_q;
      k_on_d        = 1'b0;
      k_clean_d     = 1'b0;
      done_valid_d  = 1'b0;
      done_id_d     = done_id_q;
      done_status_d = done_status_q;
      done_cycles_d = done_cycles_q;

      case (state_q)
         S_IDLE: begin
            if (!abort && pick_found_s) begin
               state_d    = S_LAUNCH;
               grant_d    = GRANT_ONE << pick_idx_s;
               k_on_d     = 1'b1;
               k_select_d = SEL_W'(req_select >> (pick_idx_s * SEL_W));
               cnt_d      = CNT_ONE;
               cur_id_d   = pick_idx_s;
               ptr_d      = pick_next_s;
            end else begin
               state_d = S_IDLE;
            end
         end

         // k_complete is deliberately not looked at here.
         S_LAUNCH: begin
            if (abort) begin
               state_d      = S_RECOVER;
               cur_status_d = ST_ABORT;
               rst_cnt_d    = RST_LOAD;
            end else begin
               state_d = S_RUN;
               cnt_d   = cnt_inc_s;
            end
         end

         // Priority: abort, then the completing event, then the watchdog.
         S_RUN: begin
            if (abort) begin
               state_d      = S_RECOVER;
               cur_status_d = ST_ABORT;
               rst_cnt_d    = RST_LOAD;
            end else if (k_complete) begin
               state_d   = S_CLEAN;
               k_clean_d = 1'b1;
               cnt_d     = cnt_inc_s;
            end else if (wd_hit_s) begin
               state_d      = S_RECOVER;
               cur_status_d = ST_TIMEOUT;
               rst_cnt_d    = RST_LOAD;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end

         S_CLEAN: begin
            if (abort) begin
               state_d      = S_RECOVER;
               cur_status_d = ST_ABORT;
               rst_cnt_d    = RST_LOAD;
            end else if (k_cleaned) begin
               state_d       = S_DONE;
               cur_status_d  = ST_OK;
               done_valid_d  = 1'b1;
               done_id_d     = cur_id_q;
               done_status_d = ST_OK;
               done_cycles_d = cnt_q;
            end else if (wd_hit_s) begin
               state_d      = S_RECOVER;
               cur_status_d = ST_TIMEOUT;
               rst_cnt_d    = RST_LOAD;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end

         // Counter is frozen; rst_cnt_q counts the remaining k_rstn-low cycles.
         S_RECOVER: begin
            if (rst_cnt_q == '0) begin
               state_d       = S_DONE;
               done_valid_d  = 1'b1;
               done_id_d     = cur_id_q;
               done_status_d = cur_status_q;
               done_cycles_d = cnt_q;
            end else begin
               rst_cnt_d = rst_cnt_q - RST_W'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Level outputs follow the state they will be registered alongside.
      k_rstn_d = (state_d != S_RECOVER);
      busy_d   = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         rst_cnt_q     <= '0;
         cur_id_q      <= '0;
         cur_status_q  <= ST_OK;
         grant_q       <= '0;
         busy_q        <= 1'b0;
         k_rstn_q      <= 1'b0;
         k_select_q    <= '0;
         k_on_q        <= 1'b0;
         k_clean_q     <= 1'b0;
         done_valid_q  <= 1'b0;
         done_id_q     <= '0;
         done_status_q <= 2'b00;
         done_cycles_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         rst_cnt_q     <= rst_cnt_d;
         cur_id_q      <= cur_id_d;
         cur_status_q  <= cur_status_d;
         grant_q       <= grant_d;
         busy_q        <= busy_d;
         k_rstn_q      <= k_rstn_d;
         k_select_q    <= k_select_d;
         k_on_q        <= k_on_d;
         k_clean_q     <= k_clean_d;
         done_valid_q  <= done_valid_d;
         done_id_q     <= done_id_d;
         done_status_q <= done_status_d;
         done_cycles_q <= done_cycles_d;
      end
   end

   assign req_grant   = grant_q;
   assign busy        = busy_q;
   assign k_rstn      = k_rstn_q;
   assign k_select    = k_select_q;
   assign k_on        = k_on_q;
   assign k_clean     = k_clean_q;
   assign done_valid  = done_valid_q;
   assign done_id     = done_id_q;
   assign done_status = done_status_q;
   assign done_cycles = done_cycles_q;

endmodule

// File: tb/tb_kernel_launch_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for kernel_launch_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=20).
// Directed launches come from a table of {stimulus, expected record} rows;
// random launches are checked against an outcome model derived from the
// launch rules (cycle of each kernel event vs. watchdog limit vs. abort).
// ---------------------------------------------------------------------------
module tb_kernel_launch_arbiter;

   localparam int N  = 4;
   localparam int SW = 8;
   localparam int CW = 48;
   localparam int TO = 20;
   localparam int RC = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*SW-1:0]   req_select;
   logic [N-1:0]      req_grant;
   logic              abort;
   logic              busy;
   logic              k_rstn;
   logic [SW-1:0]     k_select;
   logic              k_on;
   logic              k_complete;
   logic              k_clean;
   logic              k_cleaned;
   logic              done_valid;
   logic [1:0]        done_id;
   logic [1:0]        done_status;
   logic [CW-1:0]     done_cycles;

   always #5 clk = ~clk;

   kernel_launch_arbiter #(
      .NUM_REQ(N), .SEL_W(SW), .CNT_W(CW), .TIMEOUT_CYCLES(TO), .RST_CYCLES(RC)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_select(req_select),
      .req_grant(req_grant), .abort(abort), .busy(busy), .k_rstn(k_rstn),
      .k_select(k_select), .k_on(k_on), .k_complete(k_complete), .k_clean(k_clean),
      .k_cleaned(k_cleaned), .done_valid(done_valid), .done_id(done_id),
      .done_status(done_status), .done_cycles(done_cycles)
   );

   typedef struct {
      logic [N-1:0] mask;
      int           dc;      // k_complete pulse at cycle 1+dc (k_on cycle = 1)
      int           de;      // k_cleaned pulse de cycles after the k_clean cycle
      int           a;       // abort pulse at cycle 1+a, -1 = none
      int           exp_id;
      int           exp_st;
      int           exp_cyc;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int ptr_m = 0;
   logic [N*SW-1:0] sel_v;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_pick(input logic [N-1:0] m, input int p);
      logic [N-1:0] t;
      for (int o = 0; o < N; o++) begin
         t = m >> ((p + o) % N);
         if (t[0]) return (p + o) % N;
      end
      return -1;
   endfunction

   // Outcome of one launch from event cycles: ok ends when k_cleaned is seen;
   // the watchdog fires when the launch is still active at cycle TO with no
   // event exactly then; abort wins any tie and ends the launch at its cycle.
   task automatic model_outcome(input int dc, input int de, input int a,
                                output int st, output int cyc);
      int e;
      e = 2 + dc + de;
      if (e > TO && (1 + dc) != TO) begin
         st = 1; cyc = TO;
      end else begin
         st = 0; cyc = e;
      end
      if (a >= 0 && (1 + a) <= cyc) begin
         st = 2; cyc = 1 + a;
      end
   endtask

   task automatic wait_grant(input logic [N-1:0] mask, input int exp_id);
      int n;
      logic [N-1:0] exp_g;
      logic [SW-1:0] exp_sel;
      n = 0;
      req_valid = mask;
      while (req_grant == '0 && n < 12) begin
         step();
         n++;
      end
      if (req_grant == '0) begin
         check("grant_wait_expired", 64'd0, 64'd1);
      end else begin
         exp_g   = N'(1) << exp_id;
         exp_sel = SW'(sel_v >> (exp_id * SW));
         check("grant_onehot", 64'(req_grant), 64'(exp_g));
         check("k_on_with_grant", 64'(k_on), 64'd1);
         check("k_select", 64'(k_select), 64'(exp_sel));
         check("busy_launch", 64'(busy), 64'd1);
      end
      req_valid = '0;
   endtask

   task automatic run_body(input int dc, input int de, input int a,
                           input int exp_id, input int exp_st, input int exp_cyc);
      int k, done_k, rlow, ncl, non, e, exp_done, exp_cl;
      k = 1; done_k = -1; rlow = 0; ncl = 0; non = 0;
      e = 2 + dc + de;
      exp_done = (exp_st == 0) ? exp_cyc + 1 : exp_cyc + 1 + RC;
      exp_cl   = ((1 + dc) <= TO && (a < 0 || dc < a)) ? 1 : 0;
      while (k < 90 && done_k < 0) begin
         k_complete = (k == 1 + dc);
         k_cleaned  = (k == e);
         abort      = (a >= 0 && k == 1 + a);
         step();
         k++;
         if (k_clean) ncl++;
         if (!k_rstn) rlow++;
         if (k_on) non++;
         if (done_valid) begin
            done_k = k;
            check("busy_in_done", 64'(busy), 64'd1);
         end
      end
      k_complete = 1'b0; k_cleaned = 1'b0; abort = 1'b0;
      check("done_cycle_index", 64'(done_k), 64'(exp_done));
      check("done_id", 64'(done_id), 64'(exp_id));
      check("done_status", 64'(done_status), 64'(exp_st));
      check("done_cycles", 64'(done_cycles), 64'(exp_cyc));
      check("k_rstn_low_cycles", 64'(rlow), 64'(exp_st == 0 ? 0 : RC));
      check("k_clean_pulses", 64'(ncl), 64'(exp_cl));
      check("extra_k_on", 64'(non), 64'd0);
      step();
      check("idle_done_valid", 64'(done_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("done_cycles_hold", 64'(done_cycles), 64'(exp_cyc));
   endtask

   task automatic run_launch(input logic [N-1:0] mask, input int dc, input int de, input int a,
                             input int exp_id, input int exp_st, input int exp_cyc);
      wait_grant(mask, exp_id);
      run_body(dc, de, a, exp_id, exp_st, exp_cyc);
      ptr_m = (exp_id + 1) % N;
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit");
      $fatal(1);
   end

   initial begin
      vec_t vt[12];
      int   st, cyc, id, dc, de, a;
      logic [N-1:0] m;

      // mask, dc, de, abort, id, status, cycles
      vt[0]  = '{4'b1111,  3, 1, -1, 0, 0,  6};
      vt[1]  = '{4'b1111,  3, 1, -1, 1, 0,  6};
      vt[2]  = '{4'b1111,  3, 1, -1, 2, 0,  6};
      vt[3]  = '{4'b1111,  3, 1, -1, 3, 0,  6};
      vt[4]  = '{4'b1111,  3, 1, -1, 0, 0,  6};
      vt[5]  = '{4'b0001, 10, 2, -1, 0, 0, 14};   // basic launch
      vt[6]  = '{4'b0100, 30, 0, -1, 2, 1, 20};   // kernel never completes
      vt[7]  = '{4'b1000,  2, 0, -1, 3, 0,  4};   // normal after timeout
      vt[8]  = '{4'b0010,  5, 0,  5, 1, 2,  6};   // abort with k_complete
      vt[9]  = '{4'b0011,  4, 0,  0, 0, 2,  1};   // abort in LAUNCH, wraps to 0
      vt[10] = '{4'b0100, 10, 8, -1, 2, 0, 20};   // k_cleaned on the limit
      vt[11] = '{4'b1000, 19, 0, -1, 3, 0, 21};   // k_complete on the limit

      reset = 1'b1; req_valid = '0; abort = 1'b0;
      k_complete = 1'b0; k_cleaned = 1'b0;
      sel_v = {8'h44, 8'h33, 8'h22, 8'h05};
      req_select = sel_v;
      repeat (3) step();
      check("rst_grant", 64'(req_grant), 64'd0);
      check("rst_k_rstn", 64'(k_rstn), 64'd0);
      check("rst_k_on", 64'(k_on), 64'd0);
      check("rst_k_clean", 64'(k_clean), 64'd0);
      check("rst_k_select", 64'(k_select), 64'd0);
      check("rst_done_valid", 64'(done_valid), 64'd0);
      check("rst_done_cycles", 64'(done_cycles), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      step();
      check("k_rstn_after_reset", 64'(k_rstn), 64'd1);

      for (int i = 0; i < 12; i++) begin
         run_launch(vt[i].mask, vt[i].dc, vt[i].de, vt[i].a,
                    vt[i].exp_id, vt[i].exp_st, vt[i].exp_cyc);
      end

      // abort held in IDLE blocks arbitration
      abort = 1'b1;
      req_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         step();
         check("no_grant_under_abort", 64'(req_grant), 64'd0);
      end
      abort = 1'b0;
      step();
      check("grant_after_abort_falls", 64'(req_grant), 64'b0010);
      req_valid = '0;
      run_body(3, 1, -1, 1, 0, 6);
      ptr_m = 2;

      // reset in the middle of RUN, then ptr restarts at 0
      wait_grant(4'b0100, 2);
      repeat (3) step();
      reset = 1'b1;
      step();
      check("midrun_rst_k_rstn", 64'(k_rstn), 64'd0);
      check("midrun_rst_k_on", 64'(k_on), 64'd0);
      check("midrun_rst_done_valid", 64'(done_valid), 64'd0);
      check("midrun_rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      ptr_m = 0;
      run_launch(4'b0110, 3, 1, -1, 1, 0, 6);

      // random launches against the outcome model
      for (int r = 0; r < 40; r++) begin
         m     = N'($urandom_range(1, 15));
         sel_v = $urandom;
         req_select = sel_v;
         dc = $urandom_range(1, 24);
         de = $urandom_range(0, 24);
         a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : -1;
         id = rr_pick(m, ptr_m);
         model_outcome(dc, de, a, st, cyc);
         run_launch(m, dc, de, a, id, st, cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
